// File: rtl/imem_pkg.sv
// ============================================================================
// imem_pkg : shared types, latency bounds and address helpers for imem_responder
// Revision : 1.0
// ============================================================================
`default_nettype none

package imem_pkg;

    localparam int LATENCY_MIN = 1;
    localparam int LATENCY_MAX = 4;

    typedef logic [31:0] word_t;

    function automatic logic [29:0] word_index(input word_t addr);
        return addr[31:2];
    endfunction

    // True only for a word-aligned address whose index lies inside the array
    function automatic logic addr_ok(input word_t addr, input int unsigned words);
        return (addr[1:0] == 2'b00) && ({2'b00, addr[31:2]} < words);
    endfunction

endpackage

`default_nettype wire

// File: rtl/imem_resp_stage.sv
// ============================================================================
// imem_resp_stage : one response delay-line stage (valid + zero-when-idle data)
// Revision : 1.0
// ============================================================================
`default_nettype none

module imem_resp_stage
    import imem_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        in_val,
    input  logic [31:0] in_data,
    output logic        out_val,
    output logic [31:0] out_data
);

    logic  valid_q;
    logic  valid_d;
    word_t data_q;
    word_t data_d;

    always_comb begin
        valid_d = in_val;
        data_d  = in_val ? in_data : '0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign out_val  = valid_q;
    assign out_data = data_q;

endmodule

`default_nettype wire

// File: rtl/imem_responder.sv
// ============================================================================
// imem_responder : fixed-latency instruction memory with preload port,
//                  sticky error flag and wrapping request counter
// Revision : 1.0
// ============================================================================
`default_nettype none

module imem_responder
    import imem_pkg::*;
#(
    parameter int WORDS   = 256,
    parameter int LATENCY = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     imemreq_val,
    input  logic [31:0]              imemreq_addr,
    output logic                     imemresp_val,
    output logic [31:0]              imemresp_data,
    input  logic                     load_en,
    input  logic [$clog2(WORDS)-1:0] load_addr,
    input  logic [31:0]              load_data,
    output logic                     err,
    output logic [15:0]              req_count
);

    localparam int AW = $clog2(WORDS);

    generate
        if (LATENCY < LATENCY_MIN || LATENCY > LATENCY_MAX) begin : g_bad_latency
            $error("imem_responder: LATENCY must be in 1..4");
        end
        if (WORDS < 16 || WORDS > 4096 || (WORDS & (WORDS - 1)) != 0) begin : g_bad_words
            $error("imem_responder: WORDS must be a power of two in 16..4096");
        end
    endgenerate

    word_t           mem [WORDS];
    logic [29:0]     req_idx;
    logic            req_in_range;
    word_t           rd_data;
    logic [LATENCY:0] stg_val;
    word_t           stg_data [LATENCY+1];
    logic            err_q;
    logic            err_d;
    logic [15:0]     req_count_q;
    logic [15:0]     req_count_d;

    // Backing store is deliberately unreset so preloaded code survives reset
    always_ff @(posedge clk) begin
        if (load_en) begin
            mem[load_addr] <= load_data;
        end
    end

    // Read is combinational in the accept cycle, so a same-edge preload is not seen
    always_comb begin
        req_idx      = word_index(imemreq_addr);
        req_in_range = ({2'b00, req_idx} < 32'(WORDS));
        rd_data      = req_in_range ? mem[req_idx[AW-1:0]] : '0;
        err_d        = err_q | (imemreq_val & ~addr_ok(imemreq_addr, WORDS));
        req_count_d  = req_count_q + {15'b0, imemreq_val};
    end

    assign stg_val[0]  = imemreq_val;
    assign stg_data[0] = imemreq_val ? rd_data : '0;

    generate
        for (genvar i = 0; i < LATENCY; i++) begin : g_stage
            imem_resp_stage u_stage (
                .clk      (clk),
                .rst      (rst),
                .in_val   (stg_val[i]),
                .in_data  (stg_data[i]),
                .out_val  (stg_val[i+1]),
                .out_data (stg_data[i+1])
            );
        end
    endgenerate

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            err_q       <= 1'b0;
            req_count_q <= '0;
        end else begin
            err_q       <= err_d;
            req_count_q <= req_count_d;
        end
    end

    assign imemresp_val  = stg_val[LATENCY];
    assign imemresp_data = stg_data[LATENCY];
    assign err           = err_q;
    assign req_count     = req_count_q;

endmodule

`default_nettype wire

// File: tb/tb_imem_responder.sv
// ============================================================================
// tb_imem_responder : randomized + directed bench for imem_responder
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_imem_responder;

    localparam int WORDS = 256;
    localparam int LAT   = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        imemreq_val;
    logic [31:0] imemreq_addr;
    logic        imemresp_val;
    logic [31:0] imemresp_data;
    logic        load_en;
    logic [7:0]  load_addr;
    logic [31:0] load_data;
    logic        err;
    logic [15:0] req_count;

    imem_responder #(.WORDS(WORDS), .LATENCY(LAT)) dut (
        .clk           (clk),
        .rst           (rst),
        .imemreq_val   (imemreq_val),
        .imemreq_addr  (imemreq_addr),
        .imemresp_val  (imemresp_val),
        .imemresp_data (imemresp_data),
        .load_en       (load_en),
        .load_addr     (load_addr),
        .load_data     (load_data),
        .err           (err),
        .req_count     (req_count)
    );

    always #5 clk = ~clk;

    // Reference: memory image, sticky error, counter, and a response schedule keyed by edge number
    logic [31:0] m_mem [WORDS];
    logic        m_err;
    logic [15:0] m_cnt;
    logic        exp_val  [16];
    logic [31:0] exp_data [16];
    int          n = 0;
    bit          run_chk = 1'b0;
    int          errors = 0;
    int          checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (edge %0d)", name, act, exp, n);
        end
    endtask

    task automatic model_reset();
        m_err = 1'b0;
        m_cnt = '0;
        for (int i = 0; i < 16; i++) begin
            exp_val[i]  = 1'b0;
            exp_data[i] = '0;
        end
    endtask

    task automatic cycle(input logic v, input logic [31:0] a, input logic le,
                         input logic [7:0] la, input logic [31:0] ld);
        int slot;
        imemreq_val  = v;
        imemreq_addr = a;
        load_en      = le;
        load_addr    = la;
        load_data    = ld;
        @(posedge clk);
        n++;
        if (rst && v) begin
            slot           = (n + LAT - 1) % 16;
            exp_val[slot]  = 1'b1;
            exp_data[slot] = (a[31:2] < WORDS) ? m_mem[a[9:2]] : 32'h0;
            m_cnt          = m_cnt + 16'd1;
            if (a[1:0] != 2'b00 || a[31:2] >= WORDS) m_err = 1'b1;
        end
        if (le) m_mem[la] = ld;
        @(negedge clk);
    endtask

    task automatic idle();
        cycle(1'b0, 32'h0, 1'b0, 8'h0, 32'h0);
    endtask

    task automatic req(input logic [31:0] a);
        cycle(1'b1, a, 1'b0, 8'h0, 32'h0);
    endtask

    function automatic logic [31:0] rand_addr(input bit allow_bad);
        logic [31:0] a;
        int          pick;
        pick = allow_bad ? int'($urandom_range(0, 9)) : 0;
        a    = {22'h0, 8'($urandom_range(0, WORDS - 1)), 2'b00};
        if (pick == 8) a[1:0] = 2'($urandom_range(1, 3));
        if (pick == 9) begin
            a = $urandom;
            if (a[31:2] < WORDS) a[20] = 1'b1;
        end
        return a;
    endfunction

    always @(negedge clk) begin
        if (run_chk) begin
            if (!rst) begin
                chk("rst_val",   {31'h0, imemresp_val}, 32'h0);
                chk("rst_data",  imemresp_data, 32'h0);
                chk("rst_err",   {31'h0, err}, 32'h0);
                chk("rst_count", {16'h0, req_count}, 32'h0);
            end else begin
                chk("resp_val",  {31'h0, imemresp_val}, {31'h0, exp_val[n % 16]});
                chk("resp_data", imemresp_data, exp_data[n % 16]);
                chk("err",       {31'h0, err}, {31'h0, m_err});
                chk("req_count", {16'h0, req_count}, {16'h0, m_cnt});
            end
            exp_val[n % 16]  = 1'b0;
            exp_data[n % 16] = '0;
        end
    end

    initial begin
        rst = 1'b0;
        imemreq_val = 1'b0; imemreq_addr = '0;
        load_en = 1'b0; load_addr = '0; load_data = '0;
        model_reset();
        @(posedge clk);
        @(negedge clk);
        #1 run_chk = 1'b1;

        // Preload the whole array while still in reset; writes are not gated by reset
        for (int i = 0; i < WORDS; i++) cycle(1'b0, 32'h0, 1'b1, 8'(i), $urandom);
        cycle(1'b0, 32'h0, 1'b1, 8'd0, 32'h00000013);
        cycle(1'b0, 32'h0, 1'b1, 8'd1, 32'h00A00093);
        cycle(1'b0, 32'h0, 1'b1, 8'd2, 32'h00108133);
        cycle(1'b0, 32'h0, 1'b1, 8'd3, 32'hDEADBEEF);
        #2 rst = 1'b1;

        // Back-to-back fetch of four words
        req(32'h0);
        chk("t1_no_resp_yet", {31'h0, imemresp_val}, 32'h0);
        req(32'h4);
        chk("t1_val0", {31'h0, imemresp_val}, 32'h1);
        chk("t1_data0", imemresp_data, 32'h00000013);
        req(32'h8);
        chk("t1_data1", imemresp_data, 32'h00A00093);
        req(32'hC);
        chk("t1_data2", imemresp_data, 32'h00108133);
        idle();
        chk("t1_data3", imemresp_data, 32'hDEADBEEF);
        chk("t1_count", {16'h0, req_count}, 32'd4);
        chk("t1_err", {31'h0, err}, 32'h0);
        idle();
        chk("t1_drained", {31'h0, imemresp_val}, 32'h0);

        // Read and preload of the same index in the same cycle
        cycle(1'b1, 32'h4, 1'b1, 8'd1, 32'h12345678);
        req(32'h4);
        chk("t2_old_word", imemresp_data, 32'h00A00093);
        idle();
        chk("t2_new_word", imemresp_data, 32'h12345678);

        // Misaligned request
        cycle(1'b0, 32'h0, 1'b1, 8'd1, 32'h00A00093);
        chk("t3_err_before", {31'h0, err}, 32'h0);
        req(32'h6);
        chk("t3_err_next_cycle", {31'h0, err}, 32'h1);
        idle();
        chk("t3_misaligned_data", imemresp_data, 32'h00A00093);
        req(32'h0);
        idle();
        chk("t3_err_sticky", {31'h0, err}, 32'h1);

        // Out-of-range request
        req(32'h400);
        idle();
        chk("t4_val", {31'h0, imemresp_val}, 32'h1);
        chk("t4_data", imemresp_data, 32'h0);
        chk("t4_err", {31'h0, err}, 32'h1);
        idle();

        // Reset with requests still in flight
        req(32'h0);
        req(32'h4);
        req(32'h8);
        #2 rst = 1'b0;
        model_reset();
        #1;
        chk("t5_val_async", {31'h0, imemresp_val}, 32'h0);
        chk("t5_data_async", imemresp_data, 32'h0);
        chk("t5_err_async", {31'h0, err}, 32'h0);
        chk("t5_count_async", {16'h0, req_count}, 32'h0);
        idle();
        idle();
        #2 rst = 1'b1;
        repeat (3) idle();
        req(32'hC);
        idle();
        chk("t5_array_kept", imemresp_data, 32'hDEADBEEF);
        chk("t5_count", {16'h0, req_count}, 32'h1);

        // Randomized traffic: first clean addresses, then with bad ones mixed in
        for (int i = 0; i < 300; i++)
            cycle(1'($urandom_range(0, 1)), rand_addr(1'b0), 1'($urandom_range(0, 1)),
                  8'($urandom_range(0, WORDS - 1)), $urandom);
        for (int i = 0; i < 300; i++)
            cycle(1'($urandom_range(0, 1)), rand_addr(1'b1), 1'($urandom_range(0, 1)),
                  8'($urandom_range(0, WORDS - 1)), $urandom);

        #2 rst = 1'b0;
        model_reset();
        idle();
        #2 rst = 1'b1;

        // Counter wrap: 65537 accepted requests
        for (int i = 0; i < 65537; i++)
            cycle(1'b1, rand_addr(1'b0), 1'($urandom_range(0, 1)),
                  8'($urandom_range(0, WORDS - 1)), $urandom);
        chk("t6_count_wrap", {16'h0, req_count}, 32'h0001);
        chk("t6_err_clean", {31'h0, err}, 32'h0);
        repeat (LAT + 1) idle();

        run_chk = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/imem_responder.md
# imem_responder

Instruction-memory responder for the TinyRV1 pipelined processor. It serves the fetch-side request port driven by the processor control unit, accepting one request per cycle with no back-pressure. It returns the addressed 32-bit word on a response port a fixed LATENCY cycles later. A bench-side preload port writes the backing array, and a sticky error flag plus a wrapping request counter support verification.

## Interface
Parameters:
- WORDS, 256: backing array depth in 32-bit words; power of two, 16..4096.
- LATENCY, 2: request-to-response delay in cycles; legal range 1..4, anything else is an elaboration error.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  reset, asynchronous, active-low; asserted while rst==0.
- imemreq_val  input  1  request valid; always accepted.
- imemreq_addr  input  32  byte address.
- imemresp_val  output  1  response valid.
- imemresp_data  output  32  response word.
- load_en  input  1  preload write enable.
- load_addr  input  $clog2(WORDS)  preload word index.
- load_data  input  32  preload word.
- err  output  1  sticky error; misaligned or out-of-range request seen.
- req_count  output  16  accepted-request counter; wraps.

## Operation
- Word index is imemreq_addr[31:2].
- In range means imemreq_addr[31:2] < WORDS.
- Array read is sampled in the accept cycle. The data and a valid bit enter stage 1 of a LATENCY-deep delay line and shift one stage per cycle. The last stage drives imemresp_val/imemresp_data.
- No ready signal: the line shifts every cycle, and every stage may hold a live request. LATENCY responses can therefore be in flight at once.
- Out-of-range request: the response is still issued, with data 0x00000000, and err is set.
- Misaligned request (addr[1:0]!=0): returns the word at addr[31:2] if that index is in range, otherwise 0. Sets err.
- err is cleared only by reset.
- req_count increments by 1 per accepted request, modulo 2^16 (0xFFFF→0x0000).
- Preload write in the same cycle as a read of the same index: the read returns the OLD word; the new word is visible from the next cycle.
- load_en is independent of requests and may be asserted every cycle.
- When imemresp_val==0, imemresp_data holds 0. Invalid stages carry zero data, so the output is never x.
- Reset:
  - Clears all stage valids and data, err, and req_count.
  - In-flight requests are dropped, with no partial responses after deassertion.
  - Array contents are NOT reset and survive reset.
- Reset asserted mid-burst: imemresp_val falls to 0 immediately (asynchronously).

## Timing
- Request at edge N produces its response valid during the cycle after edge N+LATENCY-1. With LATENCY=1, the response is visible the cycle after the request.
- Back-to-back requests produce back-to-back responses in the same order. No reordering and no bubbles are inserted.
- Preload write lands at the edge where load_en==1 and is readable by a request at the next edge.
- err rises in the cycle after the offending request is accepted, not when its response emerges.
- req_count updates at the accept edge.
- First request may be presented the cycle after rst deasserts.
- Reset values: imemresp_val=0, imemresp_data=0, err=0, req_count=0.

## Structure
- Shared package imem_pkg holds:
  - constants LATENCY_MIN=1 and LATENCY_MAX=4;
  - typedef word_t (32-bit);
  - a function word_index(addr) returning addr[31:2];
  - a function addr_ok(addr, words) returning aligned and in-range.
- Sub-module imem_resp_stage: one delay-line stage (valid + 32-bit data, async active-low reset clearing both). It is instantiated LATENCY times via generate.
- Array is a plain unreset register array, written by the preload port.

## Test plan
- Preload index 0..3 with 0x00000013, 0x00A00093, 0x00108133, 0xDEADBEEF. Request addresses 0x0, 0x4, 0x8, 0xC back-to-back with LATENCY=2. Required: responses in consecutive cycles starting 2 cycles after the first request, in that order; req_count=4; err=0.
- Request 0x4 while load_en writes index 1 with 0x12345678 in the same cycle. Required: response 0x00A00093. A repeat request returns 0x12345678.
- Request addr 0x6 (misaligned) with index 1 holding 0x00A00093. Required: response 0x00A00093 and err=1 on the next cycle. Err stays 1 through later good requests.
- WORDS=256, request addr 0x400 (index 256). Required: response valid with data 0x00000000 and err=1.
- Issue 3 requests, then assert rst with 2 still in flight. Required: imemresp_val=0 immediately and no responses after release. req_count=0, err=0, and the preloaded array is still readable.
- Issue 65537 requests. Required: req_count=0x0001.
